coffee_ctrl_fsm: RTL and testbench

Control unit for the coffee-machine datapath (selector → adder → counter → comparator → nixie tube). Accepts coin pulses, sequences the selector/counter controls to accumulate credit, reads the comparator flags against the fixed price of 3, then dispenses, returns change and clears the credit counter. It sits beside the datapath in the top level; all datapath control inputs are driven only by this block.

---
 rtl/coffee_pkg.sv | 45 ++++
 rtl/coffee_ctrl_fsm_if.sv | 29 ++
 rtl/coffee_dispense_timer.sv | 21 ++
 rtl/coffee_ctrl_fsm.sv | 110 +++++++++++
 tb/tb_coffee_ctrl_fsm.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/coffee_pkg.sv
// coffee_pkg: shared state encoding, datapath control codes and output decode for the coffee controller.
package coffee_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_CHANGE,
        S_DISPENSE,
        S_CLEAR,
        S_REFUND
    } state_t;

    localparam int PRICE = 3;
    localparam logic SEL_ONE = 1'b0;
    localparam logic SEL_TWO = 1'b1;
    localparam logic UD_UP = 1'b1;
    localparam logic UD_DOWN = 1'b0;

    typedef struct packed {
        logic sel_en;
        logic sel_sel;
        logic cnt_ld;
        logic cnt_en;
        logic cnt_ud;
        logic coffee;
        logic change;
        logic busy;
    } ctrl_out_t;

    // Every counter step this block issues is a decrement, so cnt_ud never leaves UD_DOWN.
    function automatic ctrl_out_t decode_outputs(state_t s, logic sel, logic gap);
        ctrl_out_t o;
        o.sel_en = s == S_LOAD;
        o.sel_sel = s == S_LOAD ? sel : SEL_ONE;
        o.cnt_ld = s == S_LOAD;
        o.change = s == S_CHANGE || (s == S_REFUND && !gap);
        o.cnt_en = o.change || s == S_CLEAR;
        o.cnt_ud = UD_DOWN;
        o.coffee = s == S_DISPENSE;
        o.busy = s != S_IDLE;
        return o;
    endfunction

endpackage

// File: rtl/coffee_ctrl_fsm_if.sv
// coffee_ctrl_fsm_if: coin/comparator inputs and datapath control outputs of the coffee controller.
interface coffee_ctrl_fsm_if;
    logic Ctrl_coin_one;
    logic Ctrl_coin_two;
    logic Ctrl_cancel;
    logic Ctrl_less_3;
    logic Ctrl_eql_3;
    logic Ctrl_grt_3;
    logic Ctrl_sel_en;
    logic Ctrl_sel_sel;
    logic Ctrl_cnt_ld;
    logic Ctrl_cnt_en;
    logic Ctrl_cnt_ud;
    logic Ctrl_coffee;
    logic Ctrl_change;
    logic Ctrl_busy;

    modport master (
        output Ctrl_coin_one, Ctrl_coin_two, Ctrl_cancel, Ctrl_less_3, Ctrl_eql_3, Ctrl_grt_3,
        input  Ctrl_sel_en, Ctrl_sel_sel, Ctrl_cnt_ld, Ctrl_cnt_en, Ctrl_cnt_ud, Ctrl_coffee,
               Ctrl_change, Ctrl_busy
    );

    modport slave (
        input  Ctrl_coin_one, Ctrl_coin_two, Ctrl_cancel, Ctrl_less_3, Ctrl_eql_3, Ctrl_grt_3,
        output Ctrl_sel_en, Ctrl_sel_sel, Ctrl_cnt_ld, Ctrl_cnt_en, Ctrl_cnt_ud, Ctrl_coffee,
               Ctrl_change, Ctrl_busy
    );
endinterface

// File: rtl/coffee_dispense_timer.sv
// coffee_dispense_timer: loadable down-counter; done is high during the last counted cycle.
module coffee_dispense_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb cnt_d = start ? load_val : (cnt_q != '0 ? cnt_q - WIDTH'(1) : cnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

    assign done = cnt_q == WIDTH'(1);
endmodule

// File: rtl/coffee_ctrl_fsm.sv
// coffee_ctrl_fsm: coin-to-cup sequencer driving the selector/counter datapath.
// Defining COFFEE_CANCEL_EN builds the refund tally and REFUND state.
module coffee_ctrl_fsm
    import coffee_pkg::*;
#(
    parameter int DISPENSE_CYCLES = 8
) (
    input logic Ctrl_clock,
    input logic Ctrl_rst,
    coffee_ctrl_fsm_if.slave bus
);
    state_t state_q, state_d;
    logic sel_q, sel_d;
    ctrl_out_t out_q, out_d;
    logic coin_any, timer_start, timer_done, refund_req, refund_done, gap_d;
    logic [7:0] timer_load;
    logic [2:0] flags;

    assign coin_any = bus.Ctrl_coin_one | bus.Ctrl_coin_two;
    assign flags = {bus.Ctrl_less_3, bus.Ctrl_eql_3, bus.Ctrl_grt_3};
    // One timer serves both the dispense window and the three-step credit clear.
    assign timer_start = state_d != state_q && (state_d == S_DISPENSE || state_d == S_CLEAR);
    assign timer_load = state_d == S_CLEAR ? 8'(PRICE) : 8'(DISPENSE_CYCLES);

    coffee_dispense_timer #(.WIDTH(8)) u_timer (
        .clk(Ctrl_clock),
        .rst(Ctrl_rst),
        .start(timer_start),
        .load_val(timer_load),
        .done(timer_done)
    );

`ifdef COFFEE_CANCEL_EN
    logic [1:0] tally_q, tally_d;
    logic gap_q;

    assign refund_req = bus.Ctrl_cancel && tally_q != 2'd0;
    assign refund_done = gap_q && tally_q == 2'd0;

    always_comb begin
        tally_d = tally_q;
        if (state_q == S_IDLE && coin_any) tally_d = tally_q + (bus.Ctrl_coin_two ? 2'd2 : 2'd1);
        else if (state_d == S_DISPENSE) tally_d = 2'd0;
        else if (state_q == S_REFUND && !gap_q) tally_d = tally_q - 2'd1;
        gap_d = state_q == S_REFUND && !gap_q;
    end

    always_ff @(posedge Ctrl_clock or posedge Ctrl_rst) begin
        if (Ctrl_rst) begin
            tally_q <= 2'd0;
            gap_q <= 1'b0;
        end else begin
            tally_q <= tally_d;
            gap_q <= gap_d;
        end
    end
`else
    logic unused_cancel;
    assign unused_cancel = bus.Ctrl_cancel;
    assign refund_req = 1'b0;
    assign refund_done = 1'b0;
    assign gap_d = 1'b0;
`endif

    always_ff @(posedge Ctrl_clock or posedge Ctrl_rst) begin
        if (Ctrl_rst) begin
            state_q <= S_IDLE;
            sel_q <= SEL_ONE;
            out_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q <= sel_d;
            out_q <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d = sel_q;
        case (state_q)
            S_IDLE: begin
                if (coin_any) begin
                    state_d = S_LOAD;
                    sel_d = bus.Ctrl_coin_two ? SEL_TWO : SEL_ONE;
                end else if (refund_req) begin
                    state_d = S_REFUND;
                end
            end
            S_LOAD: state_d = S_CHECK;
            S_CHECK: state_d = flags == 3'b010 ? S_DISPENSE : (flags == 3'b001 ? S_CHANGE : S_IDLE);
            S_CHANGE: state_d = S_CHECK;
            S_DISPENSE: state_d = timer_done ? S_CLEAR : S_DISPENSE;
            S_CLEAR: state_d = timer_done ? S_IDLE : S_CLEAR;
            S_REFUND: state_d = refund_done ? S_IDLE : S_REFUND;
            default: state_d = S_IDLE;
        endcase
    end

    // Decoding the next state into a register keeps outputs glitch-free without adding latency.
    always_comb out_d = decode_outputs(state_d, sel_d, gap_d);

    assign bus.Ctrl_sel_en = out_q.sel_en;
    assign bus.Ctrl_sel_sel = out_q.sel_sel;
    assign bus.Ctrl_cnt_ld = out_q.cnt_ld;
    assign bus.Ctrl_cnt_en = out_q.cnt_en;
    assign bus.Ctrl_cnt_ud = out_q.cnt_ud;
    assign bus.Ctrl_coffee = out_q.coffee;
    assign bus.Ctrl_change = out_q.change;
    assign bus.Ctrl_busy = out_q.busy;
endmodule

// File: tb/tb_coffee_ctrl_fsm.sv
// tb_coffee_ctrl_fsm: vector table, corner-case sequences and a random run against a purchase-plan model.
// The bench emulates the credit counter/comparator so the controller sees real flags.
module tb_coffee_ctrl_fsm;
    localparam int N = 8;
    localparam logic [7:0] W_IDLE = 8'h00;
    localparam logic [7:0] W_LOAD1 = 8'hA1;
    localparam logic [7:0] W_LOAD2 = 8'hE1;
    localparam logic [7:0] W_CHECK = 8'h01;
    localparam logic [7:0] W_CHANGE = 8'h13;
    localparam logic [7:0] W_COFFEE = 8'h05;
    localparam logic [7:0] W_CLEAR = 8'h11;
    localparam logic [7:0] W_GAP = 8'h01;
`ifdef COFFEE_CANCEL_EN
    localparam bit CANCEL_EN = 1'b1;
`else
    localparam bit CANCEL_EN = 1'b0;
`endif

    typedef struct {
        logic c1;
        logic c2;
        logic cx;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int n_ld = 0, n_sel2 = 0, n_coffee = 0, n_down = 0, n_change = 0;
    int b_ld, b_sel2, b_coffee, b_down, b_change;
    logic [2:0] dp;
    logic [7:0] plan[$];
    logic [7:0] cur;
    int credit, n;
    logic r1, r2, rx;
    vec_t vecs[5];

    coffee_ctrl_fsm_if bus();

    coffee_ctrl_fsm #(.DISPENSE_CYCLES(N)) dut (
        .Ctrl_clock(clk),
        .Ctrl_rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dp <= 3'd0;
        else if (bus.Ctrl_cnt_ld) dp <= dp + (bus.Ctrl_sel_en ? (bus.Ctrl_sel_sel ? 3'd2 : 3'd1) : 3'd0);
        else if (bus.Ctrl_cnt_en) dp <= bus.Ctrl_cnt_ud ? dp + 3'd1 : dp - 3'd1;
    end

    assign bus.Ctrl_less_3 = dp < 3'd3;
    assign bus.Ctrl_eql_3 = dp == 3'd3;
    assign bus.Ctrl_grt_3 = dp > 3'd3;

    always @(negedge clk) begin
        if (!rst) begin
            n_ld <= n_ld + int'(bus.Ctrl_cnt_ld);
            n_sel2 <= n_sel2 + int'(bus.Ctrl_cnt_ld && bus.Ctrl_sel_sel);
            n_coffee <= n_coffee + int'(bus.Ctrl_coffee);
            n_down <= n_down + int'(bus.Ctrl_cnt_en && !bus.Ctrl_cnt_ud);
            n_change <= n_change + int'(bus.Ctrl_change);
        end
    end

    function automatic logic [7:0] outw();
        return {bus.Ctrl_sel_en, bus.Ctrl_sel_sel, bus.Ctrl_cnt_ld, bus.Ctrl_cnt_en,
                bus.Ctrl_cnt_ud, bus.Ctrl_coffee, bus.Ctrl_change, bus.Ctrl_busy};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic c1, input logic c2, input logic cx);
        bus.Ctrl_coin_one = c1;
        bus.Ctrl_coin_two = c2;
        bus.Ctrl_cancel = cx;
        @(posedge clk);
        #1;
        bus.Ctrl_coin_one = 1'b0;
        bus.Ctrl_coin_two = 1'b0;
        bus.Ctrl_cancel = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic snap();
        b_ld = n_ld;
        b_sel2 = n_sel2;
        b_coffee = n_coffee;
        b_down = n_down;
        b_change = n_change;
    endtask

    initial begin
        bus.Ctrl_coin_one = 1'b0;
        bus.Ctrl_coin_two = 1'b0;
        bus.Ctrl_cancel = 1'b0;
        // inputs in one cycle, expected output word in the following cycle
        vecs[0] = '{1'b0, 1'b0, 1'b0, W_IDLE};
        vecs[1] = '{1'b0, 1'b1, 1'b0, W_LOAD2};
        vecs[2] = '{1'b0, 1'b0, 1'b0, W_CHECK};
        vecs[3] = '{1'b1, 1'b0, 1'b0, W_IDLE};
        vecs[4] = '{1'b0, 1'b0, 1'b0, W_IDLE};
        do_reset();
        chk("reset_outputs", outw(), W_IDLE);
        chk("reset_credit", dp, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(vecs[i].c1, vecs[i].c2, vecs[i].cx);
            chk($sformatf("vec%0d", i), outw(), vecs[i].exp);
        end
        chk("vec_credit", dp, 2);

        // three single coins
        do_reset();
        snap();
        repeat (2) begin
            cyc(1'b1, 1'b0, 1'b0);
            repeat (2) cyc(1'b0, 1'b0, 1'b0);
        end
        cyc(1'b1, 1'b0, 1'b0);
        chk("a_load", outw(), W_LOAD1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("a_check", outw(), W_CHECK);
        cyc(1'b0, 1'b0, 1'b0);
        chk("a_coffee_rise", outw(), W_COFFEE);
        repeat (N + 2) cyc(1'b0, 1'b0, 1'b0);
        chk("a_busy_last", bus.Ctrl_busy, 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("a_busy_fall", bus.Ctrl_busy, 0);
        chk("a_loads", n_ld - b_ld, 3);
        chk("a_sel_two", n_sel2 - b_sel2, 0);
        chk("a_coffee_cycles", n_coffee - b_coffee, N);
        chk("a_down_steps", n_down - b_down, 3);
        chk("a_change", n_change - b_change, 0);
        chk("a_credit", dp, 0);

        // overpay 2+2
        do_reset();
        snap();
        cyc(1'b0, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("b_change_t3", outw(), W_CHANGE);
        cyc(1'b0, 1'b0, 1'b0);
        chk("b_check_t4", outw(), W_CHECK);
        cyc(1'b0, 1'b0, 1'b0);
        chk("b_coffee_t5", outw(), W_COFFEE);
        repeat (N + 5) cyc(1'b0, 1'b0, 1'b0);
        chk("b_change_pulses", n_change - b_change, 1);
        chk("b_down_steps", n_down - b_down, 4);
        chk("b_coffee_cycles", n_coffee - b_coffee, N);
        chk("b_credit", dp, 0);
        chk("b_idle", outw(), W_IDLE);

        // simultaneous coins, then coins ignored while dispensing
        do_reset();
        snap();
        cyc(1'b1, 1'b1, 1'b0);
        chk("c_both_load2", outw(), W_LOAD2);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("c_coffee", outw(), W_COFFEE);
        for (int i = 0; i < N - 1; i++) cyc(i[0], !i[0], 1'b0);
        repeat (6) cyc(1'b0, 1'b0, 1'b0);
        chk("c_loads", n_ld - b_ld, 2);
        chk("c_sel_two", n_sel2 - b_sel2, 1);
        chk("c_coffee_cycles", n_coffee - b_coffee, N);
        chk("c_credit", dp, 0);

        // reset in the middle of dispensing
        do_reset();
        cyc(1'b0, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 1'b0);
        chk("d_dispensing", outw(), W_COFFEE);
        #2 rst = 1'b1;
        #1 chk("d_async_clear", outw(), W_IDLE);
        @(posedge clk);
        #1;
        chk("d_reset_edge", outw(), W_IDLE);
        chk("d_reset_credit", dp, 0);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        chk("d_restart_load", outw(), W_LOAD1);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        chk("d_restart_idle", outw(), W_IDLE);
        chk("d_restart_credit", dp, 1);

        // cancel
        do_reset();
        snap();
`ifdef COFFEE_CANCEL_EN
        cyc(1'b0, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("e_pulse1", outw(), W_CHANGE);
        cyc(1'b0, 1'b0, 1'b0);
        chk("e_gap1", outw(), W_GAP);
        cyc(1'b0, 1'b0, 1'b0);
        chk("e_pulse2", outw(), W_CHANGE);
        cyc(1'b0, 1'b0, 1'b0);
        chk("e_gap2", outw(), W_GAP);
        cyc(1'b0, 1'b0, 1'b0);
        chk("e_idle", outw(), W_IDLE);
        chk("e_credit", dp, 0);
        chk("e_coffee", n_coffee - b_coffee, 0);
        chk("e_down_steps", n_down - b_down, 2);
        cyc(1'b1, 1'b0, 1'b1);
        chk("e_coin_beats_cancel", outw(), W_LOAD1);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
`else
        cyc(1'b1, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("e_cancel_ignored", outw(), W_IDLE);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        chk("e_still_idle", outw(), W_IDLE);
        chk("e_credit_kept", dp, 1);
        chk("e_change", n_change - b_change, 0);
`endif

        // random run against a plan-of-future-outputs model
        do_reset();
        plan.delete();
        cur = W_IDLE;
        credit = 0;
        for (int i = 0; i < 3000; i++) begin
            r1 = $urandom_range(0, 5) == 0;
            r2 = $urandom_range(0, 5) == 0;
            rx = $urandom_range(0, 7) == 0;
            cyc(r1, r2, rx);
            if (!cur[0]) begin
                if (r1 || r2) begin
                    n = credit + (r2 ? 2 : 1);
                    plan.push_back(r2 ? W_LOAD2 : W_LOAD1);
                    plan.push_back(W_CHECK);
                    if (n == 4) begin
                        plan.push_back(W_CHANGE);
                        plan.push_back(W_CHECK);
                    end
                    if (n >= 3) begin
                        repeat (N) plan.push_back(W_COFFEE);
                        repeat (3) plan.push_back(W_CLEAR);
                        credit = 0;
                    end else begin
                        credit = n;
                    end
                end else if (rx && CANCEL_EN && credit > 0) begin
                    repeat (credit) begin
                        plan.push_back(W_CHANGE);
                        plan.push_back(W_GAP);
                    end
                    credit = 0;
                end
            end
            cur = plan.size() > 0 ? plan.pop_front() : W_IDLE;
            chk("rand_out", outw(), cur);
            if (!cur[0]) chk("rand_credit", dp, credit);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
